// File: rtl/mmio_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding
// for the memory-mapped UART transmitter.
package mmio_pkg;

  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory store/load bus as seen by the UART: the core drives the store
// strobe, address and data; the UART returns its STATUS word on readdata.
interface mmio_uart_tx_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output dataadr, output writedata, input readdata);
  modport slave  (input memwrite, input dataadr, input writedata, output readdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART serialiser. A push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: address decode, overflow flag, baud timing
// and frame FSM. Define UART_PARITY_EN to insert an even-parity bit.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          txd,
  output logic          busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam int             FCW       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

  logic [2:0]     r_state;
  logic [CW-1:0]  r_baud;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_ovf;
`ifdef UART_PARITY_EN
  logic           r_par;
`endif

  logic           w_sel;
  logic           w_txdata_wr;
  logic           w_status_wr;
  logic           w_status_rd;
  logic           w_push_ok;
  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic           w_full;
  logic [FCW-1:0] w_count;
  logic [7:0]     w_dout;
  logic           w_baud_done;
  logic [31:0]    w_status;
  logic           w_unused;

  // Address decode: one 8-byte window, byte offset bits ignored.
  assign w_sel       = (bus.dataadr[31:3] == BASE_ADDR[31:3]);
  assign w_txdata_wr = w_sel && bus.memwrite && (bus.dataadr[2] == TXDATA_OFF[2]);
  assign w_status_wr = w_sel && bus.memwrite && (bus.dataadr[2] == STATUS_OFF[2]);
  assign w_status_rd = w_sel && (bus.dataadr[2] == STATUS_OFF[2]);
  assign w_unused    = ^{bus.dataadr[1:0], bus.writedata[31:8]};

  assign w_baud_done = (r_baud == '0);
  // Pop only from IDLE or at the very end of STOP, so frames run back to back.
  assign w_pop       = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  assign w_push_ok   = (w_count < FCW'(FIFO_DEPTH)) || w_pop;
  assign w_push      = w_txdata_wr && w_push_ok;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.writedata[7:0]),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_txdata_wr && !w_push_ok) begin
      r_ovf <= 1'b1;
    end else if (w_status_wr && bus.writedata[STAT_OVF]) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_pop) begin
      r_state <= S_START;
      r_baud  <= BAUD_LOAD;
      r_shift <= w_dout;
`ifdef UART_PARITY_EN
      r_par   <= ^w_dout;
`endif
    end else begin
      if (!w_baud_done) begin
        r_baud <= r_baud - 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_START: begin
          if (w_baud_done) begin
            r_state <= S_DATA;
            r_baud  <= BAUD_LOAD;
            r_bit   <= '0;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= BAUD_LOAD;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_state <= S_STOP;
            r_baud  <= BAUD_LOAD;
          end
        end
`endif
        S_STOP: begin
          // A non-empty FIFO is handled by the pop branch above.
          if (w_baud_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    txd = 1'b1;
    case (r_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = r_shift[0];
`ifdef UART_PARITY_EN
      S_PARITY: txd = r_par;
`endif
      default: txd = 1'b1;
    endcase
  end

  assign busy = (r_state != S_IDLE) || !w_empty;

  always_comb begin
    w_status             = '0;
    w_status[STAT_BUSY]  = busy;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_OVF]   = r_ovf;
  end

  assign bus.readdata = w_status_rd ? w_status : 32'h0;

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle MIPS data-memory bus, downstream of the processor's store port (memwrite/dataadr/writedata) and in parallel with dmem. A store to its TXDATA address pushes a byte into a small FIFO. A serialising FSM drains the FIFO as 8N1 frames on txd. A STATUS word is returned combinationally on readdata so the core can poll it with lw in the same cycle.

## Interface
- BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 8-byte register window
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥2
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
- clk  in  1  system clock, rising-edge
- reset  in  1  reset, asynchronous assert, active-low
- memwrite  in  1  store strobe from core
- dataadr  in  32  byte address from core
- writedata  in  32  store data from core
- readdata  out  32  STATUS word when STATUS is addressed, else 0; combinational
- txd  out  1  serial output, idle high
- busy  out  1  FSM not IDLE or FIFO not empty

## Operation
- Select: dataadr[31:3] == BASE_ADDR[31:3]. dataadr[2]=0 selects TXDATA; dataadr[2]=1 selects STATUS. dataadr[1:0] is ignored.
- TXDATA write: push writedata[7:0].
  - Accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky overflow is set.
- STATUS read value: {28'b0, overflow, full, empty, busy}.
- STATUS write: writedata[3]=1 clears overflow. All other bits are ignored.
- FSM states:
  - IDLE: if FIFO not empty, pop into shift register and go to START.
  - START: txd=0.
  - DATA: 8 bits, LSB first, bit index 0→7.
  - PARITY: only when compiled in.
  - STOP: txd=1. On exit, go to START with a pop if FIFO not empty (no idle gap), else go to IDLE.
- Each non-IDLE state lasts exactly CLKS_PER_BIT cycles. Timing comes from a baud counter loaded with CLKS_PER_BIT-1 on state entry that decrements to 0.
- Width rules:
  - Counter is $clog2(CLKS_PER_BIT) bits.
  - FIFO count is $clog2(FIFO_DEPTH)+1 bits.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - txd=1, busy=0, readdata=0 (unless STATUS is addressed, which shows empty=1)
  - state IDLE, FIFO empty, overflow=0
- Reset asserted mid-frame: txd returns to 1 immediately. The frame and all FIFO contents are discarded.
- Push latency: a store captured at edge k makes empty=0 after edge k. The pop occurs at edge k+1, and txd falls after edge k+1.
- Frame length: 10·CLKS_PER_BIT cycles (11· with parity).
- Back-to-back frames have zero idle cycles between stop and the next start.
- Simultaneous push and pop:
  - When full, the push is accepted and count stays at FIFO_DEPTH.
  - When empty, the push is written and the pop is not attempted that cycle.
- overflow set and clear in the same cycle: set wins.

## Configuration
- UART_PARITY_EN defined: PARITY state is inserted after DATA. txd = XOR of the 8 data bits (even parity). Frame is 11 bits.
- UART_PARITY_EN undefined: no PARITY state and no parity logic. Frame is 8N1, 10 bits.

## Structure
- Shared package mmio_pkg holds:
  - register offsets TXDATA_OFF=0 and STATUS_OFF=4
  - STATUS bit indices (BUSY=0, EMPTY=1, FULL=2, OVF=3)
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, dout, empty, full and count. Parameterised by WIDTH=8 and DEPTH.
- The core block contains the address decode, overflow flag, baud counter and FSM.

## Test plan
1. Reset released, no stores → txd=1, busy=0, lw STATUS returns 32'h2.
2. CLKS_PER_BIT=4, store 0x55 to TXDATA → txd falls after edge k+1. Sequence is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. busy drops after 40 cycles.
3. Three stores 0x01,0x02,0x03 in consecutive cycles → three contiguous frames with no idle gap between stop and start. empty=1 after the third pop.
4. With FIFO_DEPTH=8, store 10 bytes while txd is idle-blocked by the first frame. The first is popped, 8 are buffered and 1 is dropped. STATUS reads 32'hD (ovf, full, busy). A STATUS write of 32'h8 then clears overflow to give 32'h5.
5. Reset asserted at cycle 15 of a frame → txd=1 in the same cycle, busy=0, and STATUS=32'h2 after release.
6. With UART_PARITY_EN, store 0x07 → parity bit 1 and an 11-bit frame. Store 0x03 → parity bit 0.
